// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and the LSU: LSU-first with IF anti-starvation.
// Define MEM_ARB_TIMEOUT_EN to abort a memory access that receives no ack within TIMEOUT cycles.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned TIMEOUT  = 64
) (
    input  logic                  clk_i,
    input  logic                  reset,
    input  logic                  if_req_i,
    input  logic [ADDR_W-1:0]     if_addr_i,
    output logic                  if_done_o,
    output logic [DATA_W-1:0]     if_rdata_o,
    input  logic                  lsu_req_i,
    input  logic                  lsu_we_i,
    input  logic [DATA_W/8-1:0]   lsu_be_i,
    input  logic [ADDR_W-1:0]     lsu_addr_i,
    input  logic [DATA_W-1:0]     lsu_wdata_i,
    output logic                  lsu_done_o,
    output logic [DATA_W-1:0]     lsu_rdata_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [DATA_W/8-1:0]   mem_be_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic [DATA_W-1:0]     mem_wdata_o,
    input  logic                  mem_ack_i,
    input  logic [DATA_W-1:0]     mem_rdata_i,
    output logic                  err_o
);

    localparam int unsigned WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY_IF  = 2'd1,
        BUSY_LSU = 2'd2
    } state_t;

    if (MAX_WAIT < 1 || TIMEOUT < 1 || (DATA_W % 8) != 0) begin : g_bad_params
        $error("mem_port_arbiter: invalid parameter set");
    end

    state_t            r_state;
    logic [WAIT_W-1:0] r_wait;
    logic              w_idle;
    logic              w_if_elig;
    logic              w_lsu_elig;
    logic              w_if_starved;
    logic              w_grant_if;
    logic              w_grant_lsu;
    logic              w_tmo_hit;

    // A requester whose done is high this cycle sits out one arbitration
    assign w_idle       = (r_state == IDLE);
    assign w_if_elig    = if_req_i && !if_done_o;
    assign w_lsu_elig   = lsu_req_i && !lsu_done_o;
    assign w_if_starved = (r_wait == WAIT_W'(MAX_WAIT));
    assign w_grant_if   = w_idle && w_if_elig && (w_if_starved || !w_lsu_elig);
    assign w_grant_lsu  = w_idle && w_lsu_elig && !w_grant_if;

    // Counts edges IF spends requesting without a grant, including LSU busy time
    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            r_wait <= '0;
        end else if (w_grant_if || (w_idle && !if_req_i)) begin
            r_wait <= '0;
        end else if (if_req_i && (r_state != BUSY_IF) && !w_if_starved) begin
            r_wait <= r_wait + WAIT_W'(1);
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    logic [TMO_W-1:0] r_tmo;

    // An ack on the final allowed cycle takes precedence over the abort
    assign w_tmo_hit = !w_idle && !mem_ack_i && (r_tmo == TMO_W'(TIMEOUT - 1));

    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            r_tmo <= '0;
            err_o <= 1'b0;
        end else begin
            err_o <= w_tmo_hit;
            if (w_idle) begin
                r_tmo <= '0;
            end else if (!mem_ack_i) begin
                r_tmo <= r_tmo + TMO_W'(1);
            end
        end
    end
`else
    assign w_tmo_hit = 1'b0;
    assign err_o     = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_be_o    <= '0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            if_done_o   <= 1'b0;
            lsu_done_o  <= 1'b0;
            if_rdata_o  <= '0;
            lsu_rdata_o <= '0;
        end else begin
            if_done_o  <= 1'b0;
            lsu_done_o <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant_if) begin
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= 1'b0;
                        mem_be_o    <= '1;
                        mem_addr_o  <= if_addr_i;
                        mem_wdata_o <= '0;
                        r_state     <= BUSY_IF;
                    end else if (w_grant_lsu) begin
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= lsu_we_i;
                        mem_be_o    <= lsu_be_i;
                        mem_addr_o  <= lsu_addr_i;
                        mem_wdata_o <= lsu_wdata_i;
                        r_state     <= BUSY_LSU;
                    end
                end
                BUSY_IF, BUSY_LSU: begin
                    if (mem_ack_i || w_tmo_hit) begin
                        mem_req_o <= 1'b0;
                        r_state   <= IDLE;
                        if (r_state == BUSY_IF) begin
                            if_done_o  <= 1'b1;
                            if_rdata_o <= mem_ack_i ? mem_rdata_i : '1;
                        end else begin
                            lsu_done_o  <= 1'b1;
                            lsu_rdata_o <= mem_ack_i ? mem_rdata_i : '1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port instruction/data memory of the RISC-V datapath between two requesters: instruction fetch (IF) and load/store unit (LSU).
- Fixed LSU-first priority with an IF anti-starvation override.
- Forwards one transaction at a time to a variable-latency memory over a req/ack handshake and returns read data to the winning requester.
- Sits between the datapath's fetch/LSU logic and the memory wrapper.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; DATA_W/8 byte enables.
- MAX_WAIT, 4, consecutive cycles IF may be denied before it wins the next arbitration.
- TIMEOUT, 64, mem_ack wait limit in cycles; used only with the optional feature.

Ports:
- clk_i  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- if_req_i  in  1  IF request; held with if_addr_i until if_done_o.
- if_addr_i  in  ADDR_W  fetch address, read only.
- if_done_o  out  1  one-cycle pulse; if_rdata_o valid.
- if_rdata_o  out  DATA_W  fetched word.
- lsu_req_i  in  1  LSU request; held with all lsu_* fields until lsu_done_o.
- lsu_we_i  in  1  1 = store, 0 = load.
- lsu_be_i  in  DATA_W/8  byte enables.
- lsu_addr_i  in  ADDR_W  data address.
- lsu_wdata_i  in  DATA_W  store data.
- lsu_done_o  out  1  one-cycle pulse; lsu_rdata_o valid for loads.
- lsu_rdata_o  out  DATA_W  load data.
- mem_req_o  out  1  memory request, held until mem_ack_i.
- mem_we_o  out  1  write enable.
- mem_be_o  out  DATA_W/8  byte enables.
- mem_addr_o  out  ADDR_W  address.
- mem_wdata_o  out  DATA_W  write data.
- mem_ack_i  in  1  one-cycle completion; mem_rdata_i valid in the same cycle.
- mem_rdata_i  in  DATA_W  read data.
- err_o  out  1  one-cycle pulse on timeout abort.

Behaviour:
- States: IDLE, BUSY_IF, BUSY_LSU. All outputs are registered.
- Reset (asynchronous, any time, including mid-transaction): state IDLE; all mem_* outputs 0; done pulses 0; rdata outputs 0; err_o 0; wait counter 0. An in-flight memory access is abandoned. The memory is re-reset by the same signal.
- IDLE arbitration on each clock edge:
  - Eligible requesters have req high and their done not high in this cycle; done masks that requester for one cycle.
  - If wait_cnt == MAX_WAIT and IF is eligible, grant IF.
  - Otherwise LSU if eligible, else IF if eligible, else stay in IDLE.
- On grant: load mem_* from the winner's fields (IF: we=0, be=all ones); assert mem_req_o; go to BUSY_x.
- BUSY_x: hold all mem_* stable. On mem_ack_i: deassert mem_req_o, capture mem_rdata_i into x_rdata_o, pulse x_done_o for 1 cycle, return to IDLE.
  - Store completions on LSU also pulse done; lsu_rdata_o is then don't-care.
  - The other requester's rdata output holds its previous value.
- Latency with a same-cycle-ack memory: req first high at edge k → mem_req_o high after edge k → done high after edge k+1. Two cycles minimum; each extra ack-wait cycle adds 1.
- Back-to-back: there is one IDLE cycle between transactions (done cycle). A requester may keep req high through done to issue its next access, which is arbitrated on the following edge.
- Wait counter:
  - Increments, saturating at MAX_WAIT, on each edge where if_req_i is high and IF is not granted. This includes cycles spent in BUSY_LSU.
  - Cleared on IF grant, or when if_req_i is low in IDLE.
- mem_ack_i in IDLE is ignored.
- Requester fields changing while req is held are a protocol violation, not checked.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- Defined:
  - A counter runs in BUSY_x.
  - If TIMEOUT cycles elapse without mem_ack_i: drop mem_req_o, pulse x_done_o with x_rdata_o = all ones, pulse err_o in the same cycle, return to IDLE.
  - An ack arriving on the exact timeout cycle wins: normal completion, no err_o.
- Undefined: no counter; err_o tied to 0; BUSY waits indefinitely.

Test Plan:
- Reset, then IF-only read of 0x0000_0010; memory acks same cycle with 0x0050_0093 → mem_req_o high 1 cycle after req, if_done_o 2 cycles after req, if_rdata_o = 0x0050_0093, lsu_done_o stays 0.
- if_req_i and lsu_req_i rise together; LSU store of 0xDEAD_BEEF to 0x100 with be=4'b0011 → LSU served first, mem_we_o=1, mem_be_o=0011. IF granted in the IDLE cycle after lsu_done_o.
- Starvation: LSU re-requests back-to-back with ack latency 1 while IF is held (MAX_WAIT=4) → IF granted no later than the arbitration where wait_cnt hits 4, despite LSU pending. wait_cnt returns to 0 after the IF grant.
- Memory ack latency of 5 cycles on an LSU load of 0x1234_5678 → mem_* fields stable for all 5 cycles, lsu_done_o exactly 1 cycle, lsu_rdata_o = 0x1234_5678.
- Assert reset during BUSY_IF → mem_req_o and all done outputs are 0 immediately (before the next edge), state IDLE. After release, the held if_req_i is re-granted.
- With MEM_ARB_TIMEOUT_EN, TIMEOUT=8 and ack never given → after 8 cycles err_o and if_done_o pulse together, if_rdata_o = 0xFFFF_FFFF. Without the macro: no done, and err_o stays 0.
